// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin drain of NUM_CH sync FIFOs into one valid/ready stream,
// with one-cycle-latency pops captured into a 2-entry tagged output buffer.
module fifo_rr_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CH_WIDTH   = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_CH-1:0]            i_empty,
    output logic [NUM_CH-1:0]            o_rd_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_dout,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [CH_WIDTH-1:0]          o_ch
);
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                r_state, w_state_nxt;
    logic [CH_WIDTH-1:0]   r_gnt, r_rr_ptr, r_if_ch, w_off, w_pick;
    logic [CH_WIDTH:0]     w_sum;
    logic [BW-1:0]         r_burst_cnt;
    logic                  r_inflight, r_head;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [CH_WIDTH-1:0]   r_buf_ch [2];
    logic [DATA_WIDTH-1:0] w_dout [NUM_CH];
    logic [2*NUM_CH-1:0]   w_empty2;
    logic                  w_any, w_pop, w_credit_ok, w_issue, w_exit;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_dout
        assign w_dout[k] = i_dout[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotate empties so bit 0 is rr_ptr; the lowest clear bit is the next grant.
    assign w_empty2 = {i_empty, i_empty} >> r_rr_ptr;

    always_comb begin
        w_off = '0;
        w_any = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!w_empty2[i]) begin
                w_off = CH_WIDTH'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_pick      = (w_sum >= (CH_WIDTH+1)'(NUM_CH)) ? CH_WIDTH'(w_sum - (CH_WIDTH+1)'(NUM_CH)) : CH_WIDTH'(w_sum);
    assign w_pop       = o_valid && i_ready;
    assign w_credit_ok = ({1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2;
    assign w_issue     = r_state == BURST && !i_empty[r_gnt] && r_burst_cnt < BW'(BURST_LEN) && w_credit_ok;
    // A credit stall alone holds the grant; only a full burst or a real empty ends it.
    assign w_exit      = r_state == BURST && ((w_issue && r_burst_cnt == BW'(BURST_LEN - 1)) || (i_empty[r_gnt] && w_credit_ok));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (w_any ? BURST : IDLE) : (w_exit ? IDLE : BURST);
    end

    always_comb begin
        o_rd_en = w_issue ? (NUM_CH'(1) << r_gnt) : '0;
        o_valid = r_occ != 2'd0;
        o_data  = r_buf_data[r_head];
        o_ch    = r_buf_ch[r_head];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt         <= '0;
            r_rr_ptr      <= '0;
            r_burst_cnt   <= '0;
            r_inflight    <= 1'b0;
            r_if_ch       <= '0;
            r_head        <= 1'b0;
            r_occ         <= 2'd0;
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_ch[0]   <= '0;
            r_buf_ch[1]   <= '0;
        end else begin
            if (r_state == IDLE && w_any)
                r_gnt <= w_pick;
            if (w_exit) begin
                r_rr_ptr    <= (r_gnt == CH_WIDTH'(NUM_CH - 1)) ? '0 : r_gnt + 1'b1;
                r_burst_cnt <= '0;
            end else if (w_issue) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            r_inflight <= w_issue;
            r_if_ch    <= r_gnt;
            if (r_inflight) begin
                r_buf_data[r_head ^ r_occ[0]] <= w_dout[r_if_ch];
                r_buf_ch[r_head ^ r_occ[0]]   <= r_if_ch;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed bench with behavioural per-channel FIFOs and an output collector.
module tb_fifo_rr_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic [3:0]  empty;
    logic [3:0]  rd_en;
    logic [31:0] dout_flat;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [1:0]  o_ch;

    logic [7:0]  mem [4][64];
    logic [7:0]  dout [4];
    int          wp [4] = '{0, 0, 0, 0};
    int          rp [4] = '{0, 0, 0, 0};
    int          rd_cnt [4] = '{0, 0, 0, 0};
    int          bad_rd = 0;
    int          bad_oh = 0;
    int          cyc = 0;
    int          n_total = 0;
    int          n_fail = 0;
    int          base;
    logic [11:0] q_w [$];
    int          q_t [$];
    logic [11:0] e_w [$];

    fifo_rr_scheduler #(.NUM_CH(4), .DATA_WIDTH(8), .BURST_LEN(4), .CH_WIDTH(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_empty (empty),
        .o_rd_en (rd_en),
        .i_dout  (dout_flat),
        .o_valid (o_valid),
        .i_ready (ready),
        .o_data  (o_data),
        .o_ch    (o_ch)
    );

    always #5 clk = ~clk;

    assign dout_flat = {dout[3], dout[2], dout[1], dout[0]};

    always_comb begin
        for (int k = 0; k < 4; k++) empty[k] = (wp[k] == rp[k]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++) begin
            if (rd_en[k]) begin
                dout[k] <= mem[k][rp[k]];
                rp[k]   <= rp[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && ready) begin
                q_w.push_back({2'b0, o_ch, o_data});
                q_t.push_back(cyc);
            end
            for (int k = 0; k < 4; k++) begin
                if (rd_en[k]) begin
                    rd_cnt[k] = rd_cnt[k] + 1;
                    if (empty[k]) bad_rd = bad_rd + 1;
                end
            end
            if ($countones(rd_en) > 1) bad_oh = bad_oh + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int ch, input int n, input int b);
        for (int i = 0; i < n; i++) begin
            mem[ch][wp[ch]] = 8'(b + i);
            wp[ch] = wp[ch] + 1;
        end
    endtask

    task automatic exp_add(input int ch, input int d);
        e_w.push_back({4'(ch), 8'(d)});
    endtask

    function automatic int t_at(input int i);
        return (i < q_t.size()) ? q_t[i] : -1000;
    endfunction

    task automatic check_seq(input string tag);
        check({tag, "_count"}, q_w.size(), e_w.size());
        for (int i = 0; i < e_w.size(); i++)
            check($sformatf("%s_w%0d", tag, i), (i < q_w.size()) ? q_w[i] : 12'hfff, e_w[i]);
        e_w.delete();
    endtask

    task automatic clear_q();
        q_w.delete();
        q_t.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_data", o_data, 0);
        check("rst_ch", o_ch, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // contention: ch0 and ch2 alternate in bursts of 4 starting from rr_ptr=0
        clear_q();
        load(0, 8, 'h00);
        load(2, 8, 'h20);
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) exp_add(0, i);
        for (int i = 0; i < 4; i++) exp_add(2, 'h20 + i);
        for (int i = 4; i < 8; i++) exp_add(0, i);
        for (int i = 4; i < 8; i++) exp_add(2, 'h20 + i);
        check_seq("contention");
        check("burst_back_to_back", t_at(3) - t_at(0), 3);
        check("bubble_between_bursts", t_at(4) - t_at(3), 2);

        // wrap: rr_ptr is now 3, so grants go 3,0,1,2
        clear_q();
        for (int k = 0; k < 4; k++) load(k, 2, 'h50 + 2 * k);
        repeat (40) @(posedge clk);
        #1;
        exp_add(3, 'h56); exp_add(3, 'h57);
        exp_add(0, 'h50); exp_add(0, 'h51);
        exp_add(1, 'h52); exp_add(1, 'h53);
        exp_add(2, 'h54); exp_add(2, 'h55);
        check_seq("wrap");

        // reset mid-burst on ch3 (rr_ptr=3) with a word buffered and one in flight
        clear_q();
        ready = 1'b0;
        load(3, 8, 'h30);
        @(negedge clk);
        @(negedge clk);
        check("rmb_rd_c1", rd_en, 4'b1000);
        @(negedge clk);
        check("rmb_rd_c2", rd_en, 4'b1000);
        @(negedge clk);
        check("rmb_valid_c3", o_valid, 1);
        check("rmb_rd_c3", rd_en, 0);
        check("rmb_data_c3", {o_ch, o_data}, {2'd3, 8'h30});
        #1 rst_n = 1'b0;
        #1;
        check("rmb_valid_async", o_valid, 0);
        check("rmb_rd_async", rd_en, 0);
        load(1, 2, 'h10);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        check("rmb_valid_after", o_valid, 0);
        @(negedge clk);
        check("rmb_first_grant", rd_en, 4'b0010);
        repeat (40) @(posedge clk);
        #1;
        exp_add(1, 'h10); exp_add(1, 'h11);
        for (int i = 2; i < 8; i++) exp_add(3, 'h30 + i);
        check_seq("after_reset");

        // single channel latency: ch1 holds A1..A3
        clear_q();
        base = rd_cnt[1];
        load(1, 3, 'hA1);
        @(negedge clk);
        check("single_rd_c0", rd_en, 0);
        @(negedge clk);
        check("single_rd_c1", rd_en, 4'b0010);
        @(negedge clk);
        check("single_valid_c2", o_valid, 0);
        @(negedge clk);
        check("single_c3", {o_valid, o_ch, o_data}, {1'b1, 2'd1, 8'hA1});
        @(negedge clk);
        check("single_c4", {o_valid, o_ch, o_data}, {1'b1, 2'd1, 8'hA2});
        @(negedge clk);
        check("single_c5", {o_valid, o_ch, o_data}, {1'b1, 2'd1, 8'hA3});
        @(negedge clk);
        check("single_c6", {o_valid, rd_en}, 5'b0);
        check("single_pulses", rd_cnt[1] - base, 3);
        repeat (5) @(posedge clk);
        #1;

        // early empty: rr_ptr=2, ch3 has 2 words then the grant moves to ch0
        clear_q();
        load(3, 2, 'h3A);
        load(0, 3, 'h0A);
        repeat (30) @(posedge clk);
        #1;
        exp_add(3, 'h3A); exp_add(3, 'h3B);
        exp_add(0, 'h0A); exp_add(0, 'h0B); exp_add(0, 'h0C);
        check_seq("early_empty");

        // backpressure: 6-cycle stall starting at cycle 5 while 0x62 is at the head
        clear_q();
        load(0, 10, 'h60);
        repeat (5) @(posedge clk);
        #1;
        ready = 1'b0;
        base = rd_cnt[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {o_valid, o_ch, o_data}, {1'b1, 2'd0, 8'h62});
        end
        check("bp_pops_le2", (rd_cnt[0] - base) <= 2, 1);
        @(posedge clk); #1;
        ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) exp_add(0, 'h60 + i);
        check_seq("backpressure");

        check("rd_on_empty", bad_rd, 0);
        check("rd_onehot", bad_oh, 0);
        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
